// File: rtl/hazard_sb_pkg.sv
// Shared types and default constants for the register hazard scoreboard.
// Build option: HAZARD_SB_FORWARD_EN lets a fixed-latency result in its last cycle bypass to consumers.
package hazard_sb_pkg;

  localparam int SB_NREGS_DEF    = 32;
  localparam int SB_CNT_W_DEF    = 3;
  localparam int SB_KILL_CYC_DEF = 2;

  // Entries carry the widest supported countdown; narrower CNT_W values zero-extend into it.
  localparam int SB_CNT_MAX_W = 8;

  typedef logic [SB_CNT_MAX_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic    pending;
    logic    long;
    sb_cnt_t cnt;
  } sb_entry_t;

  localparam sb_entry_t SB_ENTRY_IDLE = '{pending: 1'b0, long: 1'b0, cnt: '0};
  localparam sb_cnt_t   SB_CNT_ONE    = sb_cnt_t'(1);

  // A fixed-latency producer with one cycle left can feed a consumer through the bypass.
  function automatic logic sb_fwd_ok(input sb_entry_t e);
    return e.pending && !e.long && (e.cnt == SB_CNT_ONE);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending/long/countdown state for a single architectural register.
// Issue writes take priority over retirement so a re-issued destination stays pending.
module sb_entry
  import hazard_sb_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_fixed,
  input  logic             set_long,
  input  logic [CNT_W-1:0] lat,
  input  logic             lu_clr,
  output sb_entry_t        entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= SB_ENTRY_IDLE;
    end else if (set_long) begin
      entry <= '{pending: 1'b1, long: 1'b1, cnt: '0};
    end else if (set_fixed) begin
      entry <= '{pending: 1'b1, long: 1'b0, cnt: sb_cnt_t'(lat)};
    end else if (entry.pending && entry.long) begin
      if (lu_clr) entry <= SB_ENTRY_IDLE;
    end else if (entry.pending) begin
      if (entry.cnt <= SB_CNT_ONE) entry <= SB_ENTRY_IDLE;
      else entry.cnt <= entry.cnt - SB_CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: RAW/WAW stall generation and redirect kill sequencing.
// Build option: HAZARD_SB_FORWARD_EN suppresses the stall on a source whose fixed result is one cycle away.
module hazard_scoreboard
  import hazard_sb_pkg::*;
#(
  parameter int NREGS    = SB_NREGS_DEF,
  parameter int CNT_W    = SB_CNT_W_DEF,
  parameter int KILL_CYC = SB_KILL_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_rs1,
  input  logic [$clog2(NREGS)-1:0] issue_rs2,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     use_rs1,
  input  logic                     use_rs2,
  input  logic                     use_rd,
  input  logic [CNT_W-1:0]         issue_lat,
  input  logic                     issue_long,
  input  logic                     lu_done,
  input  logic [$clog2(NREGS)-1:0] lu_rd,
  input  logic                     btaken,
  input  logic                     exception,
  input  logic                     discard,
  output logic                     stall,
  output logic                     kill,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int RW = $clog2(NREGS);
  localparam int KW = (KILL_CYC > 1) ? $clog2(KILL_CYC) : 1;

  sb_entry_t        entries [NREGS];
  logic [NREGS-1:0] long_v;
  logic [NREGS-1:0] src_busy_v;
  logic             stall_raw;
  logic             redirect;
  logic             issue_fire;
  logic             wr_en;
  logic             wr_long;
  logic             wr_fixed;
  logic [KW-1:0]    kill_cnt;

  // Issue handshake: issue_valid offers an instruction, (!stall && !kill) is the ready;
  // it is accepted (issue_fire) only in a cycle where both hold.
  assign issue_fire = issue_valid && !stall && !kill;
  assign wr_en      = issue_fire && use_rd && (issue_rd != '0);
  assign wr_long    = wr_en && issue_long;
  assign wr_fixed   = wr_en && !issue_long && (issue_lat != '0);

  for (genvar g = 0; g < NREGS; g++) begin : g_entry
    logic hit_rd;
    assign hit_rd = (issue_rd == RW'(g));

    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .set_fixed (wr_fixed && hit_rd),
      .set_long  (wr_long && hit_rd),
      .lat       (issue_lat),
      .lu_clr    (lu_done && (lu_rd == RW'(g))),
      .entry     (entries[g])
    );

    assign busy_vec[g] = entries[g].pending;
    assign long_v[g]   = entries[g].pending && entries[g].long;
`ifdef HAZARD_SB_FORWARD_EN
    assign src_busy_v[g] = entries[g].pending && !sb_fwd_ok(entries[g]);
`else
    assign src_busy_v[g] = entries[g].pending;
`endif
  end

  always_comb begin
    stall_raw = 1'b0;
    if (issue_valid) begin
      stall_raw = (use_rs1 && src_busy_v[issue_rs1]) ||
                  (use_rs2 && src_busy_v[issue_rs2]) ||
                  (use_rd && long_v[issue_rd])       ||
                  (issue_long && (|long_v));
    end
  end

  // A stalled instruction must not be squashed: the redirect is honoured once the stall drops.
  assign redirect = btaken || exception;
  assign kill     = (redirect || (kill_cnt != '0)) && !discard && !stall_raw;
  assign stall    = stall_raw && !kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      kill_cnt <= '0;
    end else if (redirect && kill) begin
      kill_cnt <= KW'(KILL_CYC - 1);
    end else if (kill_cnt != '0) begin
      kill_cnt <= kill_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
// Expected values are hand-derived from the scoreboard's timing rules.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        use_rs1, use_rs2, use_rd;
  logic [2:0]  issue_lat;
  logic        issue_long;
  logic        lu_done;
  logic [4:0]  lu_rd;
  logic        btaken, exception, discard;
  logic        stall, kill;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .use_rs1     (use_rs1),
    .use_rs2     (use_rs2),
    .use_rd      (use_rd),
    .issue_lat   (issue_lat),
    .issue_long  (issue_long),
    .lu_done     (lu_done),
    .lu_rd       (lu_rd),
    .btaken      (btaken),
    .exception   (exception),
    .discard     (discard),
    .stall       (stall),
    .kill        (kill),
    .busy_vec    (busy_vec)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    issue_lat = '0; issue_long = 1'b0; lu_done = 1'b0; lu_rd = '0;
    btaken = 1'b0; exception = 1'b0; discard = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    checks++;
    if (stall !== 1'b0 || kill !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: stall=%b kill=%b expected 0/0", stall, kill);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed_latency();
    int stalls = 0;
    int exp_stalls;
    bit done = 1'b0;
`ifdef HAZARD_SB_FORWARD_EN
    exp_stalls = 2;
`else
    exp_stalls = 3;
`endif
    clear_inputs();
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd5; issue_lat = 3'd3;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL fixed_issue: stall=%b expected 0", stall); end
    step();
    clear_inputs();
    issue_valid = 1'b1; use_rs1 = 1'b1; issue_rs1 = 5'd5;
    #1;
    checks++;
    if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL fixed_busy: got %h expected 00000020", busy_vec); end
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      else done = 1'b1;
      step();
    end
    issue_valid = 1'b0;
    checks++;
    if (!done || stalls != exp_stalls) begin
      errors++; $display("FAIL fixed_stall_cycles: got %0d (issued=%b) expected %0d", stalls, done, exp_stalls);
    end
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL fixed_retired: got %h expected 0", busy_vec); end
    step();
  endtask

  task automatic test_long_latency();
    int stalls = 0;
    clear_inputs();
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd7; issue_long = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL long_issue: stall=%b expected 0", stall); end
    step();
    clear_inputs();
    issue_valid = 1'b1; use_rs2 = 1'b1; issue_rs2 = 5'd7;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      step();
    end
    lu_done = 1'b1; lu_rd = 5'd7;
    @(negedge clk);
    if (stall === 1'b1) stalls++;
    checks++;
    if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL long_busy_at_done: got %b expected 1", busy_vec[7]); end
    checks++;
    if (stalls != 20) begin errors++; $display("FAIL long_stall_cycles: got %0d expected 20", stalls); end
    step();
    lu_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_vec[7] !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL long_release: busy7=%b stall=%b expected 0/0", busy_vec[7], stall);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_redirect();
    logic [2:0] exp_kill;
    logic [2:0] got_kill;
    clear_inputs();
    btaken = 1'b1;
    @(negedge clk); got_kill[0] = kill; step();
    btaken = 1'b0;
    @(negedge clk); got_kill[1] = kill; step();
    @(negedge clk); got_kill[2] = kill; step();
    exp_kill = 3'b011;
    checks++;
    if (got_kill !== exp_kill) begin errors++; $display("FAIL btaken_kill: got %b expected %b", got_kill, exp_kill); end
    discard = 1'b1; btaken = 1'b1;
    @(negedge clk);
    checks++;
    if (kill !== 1'b0) begin errors++; $display("FAIL discard_kill: got %b expected 0", kill); end
    step();
    discard = 1'b0; btaken = 1'b0;
    @(negedge clk);
    checks++;
    if (kill !== 1'b0) begin errors++; $display("FAIL discard_no_tail: got %b expected 0", kill); end
    step();
    exception = 1'b1;
    @(negedge clk); got_kill[0] = kill; step();
    exception = 1'b0;
    @(negedge clk); got_kill[1] = kill; step();
    @(negedge clk); got_kill[2] = kill; step();
    checks++;
    if (got_kill !== exp_kill) begin errors++; $display("FAIL exception_kill: got %b expected %b", got_kill, exp_kill); end
  endtask

  task automatic test_kill_vs_stall();
    clear_inputs();
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd4; issue_long = 1'b1;
    step();
    clear_inputs();
    issue_valid = 1'b1; use_rs1 = 1'b1; issue_rs1 = 5'd4;
    btaken = 1'b1; lu_done = 1'b1; lu_rd = 5'd4;
    @(negedge clk);
    checks++;
    if (kill !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL stall_beats_kill: kill=%b stall=%b expected 0/1", kill, stall);
    end
    step();
    lu_done = 1'b0;
    @(negedge clk);
    checks++;
    if (kill !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL kill_after_stall: kill=%b stall=%b expected 1/0", kill, stall);
    end
    step();
    btaken = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (kill !== 1'b1) begin errors++; $display("FAIL kill_hold: got %b expected 1", kill); end
    step();
    @(negedge clk);
    checks++;
    if (kill !== 1'b0) begin errors++; $display("FAIL kill_end: got %b expected 0", kill); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] got_busy;
    clear_inputs();
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd6; issue_lat = 3'd1;
    step();
    issue_lat = 3'd3;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reissue_stall: got %b expected 0", stall); end
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got_busy[i] = busy_vec[6];
      step();
    end
    checks++;
    if (got_busy !== 4'b0111) begin errors++; $display("FAIL issue_wins_retire: got %b expected 0111", got_busy); end
  endtask

  task automatic test_rd_zero();
    clear_inputs();
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd0; issue_lat = 3'd4;
    step();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd0; use_rd = 1'b1; issue_long = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL rd0_busy: got %h expected 0", busy_vec); end
    step();
    clear_inputs();
    issue_valid = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; issue_long = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || busy_vec !== 32'h0) begin
      errors++; $display("FAIL rd0_no_stall: stall=%b busy=%h expected 0/0", stall, busy_vec);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd3; issue_lat = 3'd5;
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0000_0008) begin errors++; $display("FAIL mid_pending: got %h expected 00000008", busy_vec); end
    step();
    rst = 1'b1;
    issue_valid = 1'b1; use_rd = 1'b1; issue_rd = 5'd9; issue_lat = 3'd2;
    step();
    rst = 1'b0;
    clear_inputs();
    issue_valid = 1'b1; use_rs1 = 1'b1; issue_rs1 = 5'd3; use_rs2 = 1'b1; issue_rs2 = 5'd9;
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%h stall=%b expected 0/0", busy_vec, stall);
    end
    step();
    clear_inputs();
  endtask

  // sequence and final report
  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_fixed_latency();
    test_long_latency();
    test_redirect();
    test_kill_vs_stall();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of architectural registers tracked; register index width is $clog2(NREGS).
REQ-002 SHALL have parameter CNT_W, default 3: width of the per-register latency counter.
REQ-003 SHALL have parameter KILL_CYC, default 2: number of consecutive cycles kill is held after a redirect.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port issue_valid, input, 1 bit: a decoded instruction is presented this cycle.
REQ-007 SHALL have ports issue_rs1, issue_rs2, issue_rd, input, $clog2(NREGS) bits each: source and destination register indices.
REQ-008 SHALL have ports use_rs1, use_rs2, use_rd, input, 1 bit each: the corresponding field is meaningful.
REQ-009 SHALL have port issue_lat, input, CNT_W bits: cycles until the fixed-latency result is written back.
REQ-010 SHALL have port issue_long, input, 1 bit: destination is produced by the variable-latency unit (AES/mul).
REQ-011 SHALL have port lu_done, input, 1 bit: the long unit writes back this cycle.
REQ-012 SHALL have port lu_rd, input, $clog2(NREGS) bits: the register written back by the long unit.
REQ-013 SHALL have ports btaken, exception, discard, input, 1 bit each: redirect sources, and a redirect-suppress.
REQ-014 SHALL have port stall, output, 1 bit: hold the issue stage this cycle.
REQ-015 SHALL have port kill, output, 1 bit: squash the issue-stage instruction.
REQ-016 SHALL have port busy_vec, output, NREGS bits: pending bit per register, for debug.

Function
REQ-017 SHALL store, per register, a pending bit, a CNT_W countdown and a long flag; register 0 SHALL never become pending.
REQ-018 SHALL accept an instruction (issue_fire) when issue_valid && !stall && !kill.
REQ-019 SHALL, on issue_fire with use_rd, rd≠0 and issue_lat≠0 (fixed latency), set pending, cnt=issue_lat and long=0 on the next edge.
REQ-020 SHALL, on issue_fire with use_rd, rd≠0 and issue_long=1, set pending and long=1; the entry clears only on lu_done with lu_rd equal to that register.
REQ-021 SHALL, on issue_fire with issue_lat=0 and issue_long=0, write no entry.
REQ-022 SHALL decrement each fixed-latency pending count every cycle; an entry whose cnt is 1 SHALL clear pending on the next edge.
REQ-023 SHALL, when issue and retire/lu_done target the same register in the same cycle, let the issue win: the entry stays pending with the new values.
REQ-024 SHALL assert stall_raw when issue_valid and any of: (use_rs1 && pending[rs1]), (use_rs2 && pending[rs2]), (use_rd && long[rd]) as WAW on the long unit, or (issue_long && any long entry pending).
REQ-025 SHALL compute kill = (btaken || exception || kill_cnt≠0) && !discard && !stall_raw.
REQ-026 SHALL compute stall = stall_raw && !kill.
REQ-027 SHALL reload kill_cnt to KILL_CYC-1 on a redirect that produces kill, and decrement it while nonzero; a new redirect SHALL reload it.
REQ-028 SHALL keep stall and kill combinational from the current state and inputs, with zero cycles of latency.

Reset
REQ-029 SHALL, while rst is high, clear every entry, kill_cnt and busy_vec; stall and kill SHALL read 0 with issue_valid and btaken low.
REQ-030 SHALL let rst asserted mid-operation override all issue, retire and lu_done events in that cycle.

Configuration
REQ-031 SHALL, with HAZARD_SB_FORWARD_EN defined, not stall a source whose entry has long=0 and cnt=1, because a bypass supplies the value; without it, such a source SHALL stall until pending clears.

Structure
REQ-032 SHALL place the sb_entry_t typedef (pending, long, cnt) and default constants in package hazard_sb_pkg.
REQ-033 SHALL instantiate NREGS copies of sub-module sb_entry, one per register, holding update and countdown logic; arbitration stays in the top level.

Verification
REQ-034 SHALL verify: issue rd=5, lat=3, then rs1=5 every cycle -> stall for 3 cycles without the macro, 2 cycles with it, then issue.
REQ-035 SHALL verify: issue_long rd=7, lu_done after 20 cycles -> rs2=7 stalls 20 cycles and busy_vec[7] clears one edge after lu_done.
REQ-036 SHALL verify: btaken pulse, KILL_CYC=2 -> kill high for 2 cycles; with discard=1 -> kill stays 0.
REQ-037 SHALL verify: stall_raw and btaken in the same cycle -> kill=0, stall=1; stall_raw cleared the next cycle -> kill=1.
REQ-038 SHALL verify: issue rd=0, lat=4 -> busy_vec stays 0 and no later stall.
REQ-039 SHALL verify: rst asserted while rd=3 is pending -> busy_vec=0 on the next cycle and rs1=3 does not stall.
